// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Definitions shared by the pipeline-register slice (pipe_stage_latch and
//   pipe_data_slot).
//   - WORD_W          : native datapath word width
//   - CH_PC..CH_B     : channel index of each field inside a packed stage word
//   - NOP_INSTR       : instruction encoding used as a pipeline bubble
//   - occ_state_t     : occupancy state of a stage (EMPTY / ONE / FULL)
//   - occ_count()     : number of entries held in a given occupancy state
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int WORD_W = 32;

    // Channel k of a stage word lives at [k*WIDTH +: WIDTH].
    localparam int CH_PC = 0;
    localparam int CH_IR = 1;
    localparam int CH_A  = 2;
    localparam int CH_B  = 3;

    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Encodings are chosen so that the state value equals the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    function automatic logic [1:0] occ_count(input occ_state_t state);
        logic [1:0] count;
        case (state)
            OCC_ONE:  count = 2'd1;
            OCC_FULL: count = 2'd2;
            default:  count = 2'd0;
        endcase
        return count;
    endfunction

endpackage

// File: rtl/pipe_data_slot.sv
// ---------------------------------------------------------------------------
// pipe_data_slot
//   One storage slot of a pipeline register: NUM_CH channels of WIDTH bits,
//   loaded together when load=1, cleared asynchronously to RESET_VAL
//   (replicated into every bit) while reset is low.
// Ports
//   clk    in   1              rising-edge clock
//   reset  in   1              asynchronous, active-low clear
//   load   in   1              capture d on the next rising edge
//   d      in   NUM_CH*WIDTH   next slot contents
//   q      out  NUM_CH*WIDTH   current slot contents
// ---------------------------------------------------------------------------
module pipe_data_slot
    import pipe_pkg::*;
#(
    parameter int   WIDTH     = WORD_W,
    parameter int   NUM_CH    = 4,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [NUM_CH*WIDTH-1:0] d,
    output logic [NUM_CH*WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] ch_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ch_reg <= {WIDTH{RESET_VAL}};
                end else if (load) begin
                    ch_reg <= d[gi*WIDTH +: WIDTH];
                end
            end

            assign q[gi*WIDTH +: WIDTH] = ch_reg;
        end
    endgenerate

endmodule

// File: rtl/pipe_stage_latch.sv
// ---------------------------------------------------------------------------
// pipe_stage_latch
//   Inter-stage pipeline register (F/D, D/X, X/M, M/W) carrying NUM_CH
//   channels of WIDTH bits with a valid/ready handshake. A 2-entry skid
//   buffer (main + skid slot) gives full throughput while in_ready stays a
//   pure register output. flush squashes every held entry synchronously.
//
// Optional feature: define PIPE_STAGE_PERF_EN to add the saturating
//   stall_cycles / bubble_cycles counters (and the CNT_W parameter).
//
// Ports
//   clk           in   1              rising-edge clock
//   reset         in   1              asynchronous, active-low reset
//   flush         in   1              synchronous squash of all entries
//   in_valid      in   1              upstream has data
//   in_ready      out  1              stage can accept (registered)
//   in_data       in   NUM_CH*WIDTH   channel k at [k*WIDTH +: WIDTH]
//   out_valid     out  1              main slot holds valid data
//   out_ready     in   1              downstream accepts (0 = stall)
//   out_data      out  NUM_CH*WIDTH   main slot contents
//   occupancy     out  2              entries held: 0, 1 or 2
//   stall_cycles  out  CNT_W          cycles with out_valid & !out_ready
//   bubble_cycles out  CNT_W          cycles with !out_valid & !flush
// ---------------------------------------------------------------------------
module pipe_stage_latch
    import pipe_pkg::*;
#(
    parameter int   WIDTH     = WORD_W,
    parameter int   NUM_CH    = 4,
    parameter logic RESET_VAL = 1'b0
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int   CNT_W     = 32
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [1:0]              occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic [CNT_W-1:0]        bubble_cycles
`endif
);

    localparam int DATA_W = NUM_CH * WIDTH;

    occ_state_t        state_reg;
    occ_state_t        state_next;
    logic              in_ready_reg;

    logic              accept;
    logic              pop;
    logic              load_main;
    logic              load_skid;
    logic              main_from_skid;

    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    assign out_valid = (state_reg != OCC_EMPTY);
    assign accept    = in_valid & in_ready_reg;
    assign pop       = out_valid & out_ready;

    // -----------------------------------------------------------------------
    // Occupancy FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= OCC_EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            // in_ready is computed from the next state so it is already
            // correct in the first cycle of that state, with no comb path
            // from out_ready.
            in_ready_reg <= (state_next != OCC_FULL);
        end
    end

    // -----------------------------------------------------------------------
    // Occupancy FSM: next state and slot load controls
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;

        if (flush) begin
            // Squash: drop everything, including this cycle's input. The data
            // slots are left untouched; only the valid state is cleared.
            state_next = OCC_EMPTY;
        end else begin
            case (state_reg)
                OCC_EMPTY: begin
                    if (accept) begin
                        load_main  = 1'b1;
                        state_next = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        // Downstream stalled in the same cycle we accepted:
                        // park the newcomer in the skid slot.
                        load_skid  = 1'b1;
                        state_next = OCC_FULL;
                    end else if (pop) begin
                        state_next = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so accept cannot occur.
                    if (pop) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_next     = OCC_ONE;
                    end
                end
                default: begin
                    state_next = OCC_EMPTY;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Data slots
    // -----------------------------------------------------------------------
    assign main_d = main_from_skid ? skid_q : in_data;

    pipe_data_slot #(
        .WIDTH     (WIDTH),
        .NUM_CH    (NUM_CH),
        .RESET_VAL (RESET_VAL)
    ) u_main_slot (
        .clk   (clk),
        .reset (reset),
        .load  (load_main),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_slot #(
        .WIDTH     (WIDTH),
        .NUM_CH    (NUM_CH),
        .RESET_VAL (RESET_VAL)
    ) u_skid_slot (
        .clk   (clk),
        .reset (reset),
        .load  (load_skid),
        .d     (in_data),
        .q     (skid_q)
    );

    assign in_ready  = in_ready_reg;
    assign out_data  = main_q;
    assign occupancy = occ_count(state_reg);

`ifdef PIPE_STAGE_PERF_EN
    // -----------------------------------------------------------------------
    // Performance counters: saturate at all-ones, cleared only by reset.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] bubble_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (!out_valid && !flush && (bubble_cnt_reg != '1)) begin
                bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cycles  = stall_cnt_reg;
    assign bubble_cycles = bubble_cnt_reg;
`endif

endmodule
